// File: rtl/cga_palette_ctrl.sv
// -----------------------------------------------------------------------------
// cga_palette_ctrl
//   Programmable 16-entry IRGB palette with a VGA-DAC-style CPU interface.
//   Maps the 4-bit video index to 6/7/6-bit DAC codes through a registered
//   lookup.
//
//   CPU palette writes gather an R,G,B triplet, park it in a holding register,
//   and commit it into the palette during blanking. This keeps active video
//   free of write glitches. If a second triplet completes while one is still
//   parked, the parked one is committed at once so that no data is lost.
//
//   Optional feature macro: CGA_PAL_READBACK_EN
//     defined   : data-port reads return committed palette components.
//     undefined : data-port reads return 8'h00.
// -----------------------------------------------------------------------------
module cga_palette_ctrl #(
  parameter int PAL_ENTRIES = 16,
  parameter int COMP_W      = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        bus_addr,
  input  logic [7:0]        bus_din,
  input  logic              bus_wr,
  input  logic              bus_rd,
  output logic [7:0]        bus_dout,
  input  logic [3:0]        video,
  input  logic              blank,
  output logic [COMP_W-1:0] red,
  output logic [COMP_W:0]   green,
  output logic [COMP_W-1:0] blue,
  output logic              busy
);

  localparam int ENT_W = 3 * COMP_W;

  // Write sequencer phases: which component the next data write supplies.
  localparam logic [1:0] PH_R = 2'd0;
  localparam logic [1:0] PH_G = 2'd1;
  localparam logic [1:0] PH_B = 2'd2;

  // Standard CGA component levels.
  localparam logic [COMP_W-1:0] LVL_ZERO = 6'h00;
  localparam logic [COMP_W-1:0] LVL_BASE = 6'h2A;
  localparam logic [COMP_W-1:0] LVL_INT  = 6'h15;

  // One CGA component: base level when the colour bit is set, plus the
  // intensity contribution; the two levels occupy disjoint bits.
  function automatic logic [COMP_W-1:0] cga_level(input logic on_bit,
                                                  input logic inten);
    logic [COMP_W-1:0] lvl;
    lvl = LVL_ZERO;
    if (on_bit) begin
      lvl = lvl | LVL_BASE;
    end else begin
      lvl = lvl;
    end
    if (inten) begin
      lvl = lvl | LVL_INT;
    end else begin
      lvl = lvl;
    end
    return lvl;
  endfunction

  // Power-on palette entry {R,G,B}. Entry 6 halves green to give brown
  // instead of dark yellow, as real CGA monitors do.
  function automatic logic [ENT_W-1:0] default_entry(input logic [3:0] idx);
    logic [COMP_W-1:0] r;
    logic [COMP_W-1:0] g;
    logic [COMP_W-1:0] b;
    r = cga_level(idx[2], idx[3]);
    b = cga_level(idx[0], idx[3]);
    if (idx == 4'h6) begin
      g = LVL_INT;
    end else begin
      g = cga_level(idx[1], idx[3]);
    end
    return {r, g, b};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0]  pal_q [PAL_ENTRIES];
  logic [ENT_W-1:0]  pal_d [PAL_ENTRIES];

  logic [1:0]        wr_phase_q, wr_phase_d;
  logic [3:0]        wr_idx_q,   wr_idx_d;
  logic [COMP_W-1:0] r_lat_q,    r_lat_d;
  logic [COMP_W-1:0] g_lat_q,    g_lat_d;
  logic [3:0]        hold_idx_q, hold_idx_d;
  logic [ENT_W-1:0]  hold_rgb_q, hold_rgb_d;
  logic              busy_q,     busy_d;

  logic [3:0]        rd_idx_q,   rd_idx_d;
  logic [1:0]        rd_phase_q, rd_phase_d;
  logic [7:0]        dout_q,     dout_d;

  logic [COMP_W-1:0] red_q,   red_d;
  logic [COMP_W:0]   green_q, green_d;
  logic [COMP_W-1:0] blue_q,  blue_d;

  // Decoded bus strobes and sequencer outputs.
  logic wr_widx_s;
  logic wr_data_s;
  logic wr_ridx_s;
  logic lat_r_en_s;
  logic lat_g_en_s;
  logic triplet_done_s;
  logic commit_s;

  // Data writes only carry six component bits; the top two are don't-care.
  logic unused_din_s;
  assign unused_din_s = ^bus_din[7:6];

  assign wr_widx_s = bus_wr && (bus_addr == 2'd0);
  assign wr_data_s = bus_wr && (bus_addr == 2'd1);
  assign wr_ridx_s = bus_wr && (bus_addr == 2'd2);

  // ---------------------------------------------------------------------------
  // Write sequencer FSM
  // ---------------------------------------------------------------------------

  // State register for the write phase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_phase_q <= PH_R;
    end else begin
      wr_phase_q <= wr_phase_d;
    end
  end

  // Next phase: an index write restarts the triplet, data writes step R->G->B.
  always_comb begin
    wr_phase_d = wr_phase_q;
    if (wr_widx_s) begin
      wr_phase_d = PH_R;
    end else if (wr_data_s) begin
      case (wr_phase_q)
        PH_R:    wr_phase_d = PH_G;
        PH_G:    wr_phase_d = PH_B;
        PH_B:    wr_phase_d = PH_R;
        default: wr_phase_d = PH_R;
      endcase
    end else begin
      wr_phase_d = wr_phase_q;
    end
  end

  // Phase outputs: which latch a data write fills, or whether it ends a triplet.
  always_comb begin
    lat_r_en_s     = 1'b0;
    lat_g_en_s     = 1'b0;
    triplet_done_s = 1'b0;
    if (wr_data_s) begin
      case (wr_phase_q)
        PH_R:    lat_r_en_s     = 1'b1;
        PH_G:    lat_g_en_s     = 1'b1;
        PH_B:    triplet_done_s = 1'b1;
        default: triplet_done_s = 1'b0;
      endcase
    end else begin
      triplet_done_s = 1'b0;
    end
  end

  // A parked triplet goes in during blanking, or immediately when a newer
  // triplet needs the holding register.
  assign commit_s = busy_q && (blank || triplet_done_s);

  // ---------------------------------------------------------------------------
  // Write datapath: component latches, write index, holding register
  // ---------------------------------------------------------------------------

  // Latch components and load the holding register when a triplet completes.
  always_comb begin
    r_lat_d    = lat_r_en_s ? bus_din[COMP_W-1:0] : r_lat_q;
    g_lat_d    = lat_g_en_s ? bus_din[COMP_W-1:0] : g_lat_q;
    hold_idx_d = hold_idx_q;
    hold_rgb_d = hold_rgb_q;
    busy_d     = busy_q;
    wr_idx_d   = wr_idx_q;

    if (wr_widx_s) begin
      wr_idx_d = bus_din[3:0];
    end else if (triplet_done_s) begin
      wr_idx_d = wr_idx_q + 4'd1;
    end else begin
      wr_idx_d = wr_idx_q;
    end

    if (triplet_done_s) begin
      hold_idx_d = wr_idx_q;
      hold_rgb_d = {r_lat_q, g_lat_q, bus_din[COMP_W-1:0]};
      busy_d     = 1'b1;
    end else if (commit_s) begin
      busy_d     = 1'b0;
    end else begin
      busy_d     = busy_q;
    end
  end

  // Next palette contents: only the parked entry changes, and only on commit.
  always_comb begin
    for (int i = 0; i < PAL_ENTRIES; i++) begin
      pal_d[i] = (commit_s && (hold_idx_q == 4'(i))) ? hold_rgb_q : pal_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Video lookup (reads pal_q, so a same-cycle commit is not yet visible)
  // ---------------------------------------------------------------------------

  // Registered colour lookup, forced to black during blanking.
  always_comb begin
    logic [ENT_W-1:0] ent;
    ent = pal_q[video];
    if (blank) begin
      red_d   = {COMP_W{1'b0}};
      green_d = {(COMP_W + 1){1'b0}};
      blue_d  = {COMP_W{1'b0}};
    end else begin
      red_d   = ent[ENT_W-1 -: COMP_W];
      green_d = {ent[2*COMP_W-1 -: COMP_W], ent[2*COMP_W-1]};
      blue_d  = ent[COMP_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // CPU read path (all reads see pre-write state)
  // ---------------------------------------------------------------------------

  // Read mux plus read-index sequencing; index writes override stepping.
  always_comb begin
    logic [ENT_W-1:0] rd_ent;
    rd_ent     = pal_q[rd_idx_q];
    dout_d     = dout_q;
    rd_idx_d   = rd_idx_q;
    rd_phase_d = rd_phase_q;

    if (bus_rd) begin
      case (bus_addr)
        2'd0:    dout_d = {4'b0000, wr_idx_q};
        2'd2:    dout_d = {4'b0000, rd_idx_q};
        2'd3:    dout_d = {7'b0000000, busy_q};
`ifdef CGA_PAL_READBACK_EN
        2'd1: begin
          case (rd_phase_q)
            PH_R: begin
              dout_d     = {2'b00, rd_ent[ENT_W-1 -: COMP_W]};
              rd_phase_d = PH_G;
            end
            PH_G: begin
              dout_d     = {2'b00, rd_ent[2*COMP_W-1 -: COMP_W]};
              rd_phase_d = PH_B;
            end
            PH_B: begin
              dout_d     = {2'b00, rd_ent[COMP_W-1:0]};
              rd_phase_d = PH_R;
              rd_idx_d   = rd_idx_q + 4'd1;
            end
            default: begin
              dout_d     = 8'h00;
              rd_phase_d = PH_R;
            end
          endcase
        end
`else
        2'd1:    dout_d = 8'h00;
`endif
        default: dout_d = 8'h00;
      endcase
    end else begin
      dout_d = dout_q;
    end

    if (wr_ridx_s) begin
      rd_idx_d   = bus_din[3:0];
      rd_phase_d = PH_R;
    end else begin
      rd_phase_d = rd_phase_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Datapath and output registers; reset drops any parked triplet and
  // restores the CGA palette.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < PAL_ENTRIES; i++) begin
        pal_q[i] <= default_entry(4'(i));
      end
      wr_idx_q   <= 4'd0;
      r_lat_q    <= {COMP_W{1'b0}};
      g_lat_q    <= {COMP_W{1'b0}};
      hold_idx_q <= 4'd0;
      hold_rgb_q <= {ENT_W{1'b0}};
      busy_q     <= 1'b0;
      rd_idx_q   <= 4'd0;
      rd_phase_q <= PH_R;
      dout_q     <= 8'h00;
      red_q      <= {COMP_W{1'b0}};
      green_q    <= {(COMP_W + 1){1'b0}};
      blue_q     <= {COMP_W{1'b0}};
    end else begin
      for (int i = 0; i < PAL_ENTRIES; i++) begin
        pal_q[i] <= pal_d[i];
      end
      wr_idx_q   <= wr_idx_d;
      r_lat_q    <= r_lat_d;
      g_lat_q    <= g_lat_d;
      hold_idx_q <= hold_idx_d;
      hold_rgb_q <= hold_rgb_d;
      busy_q     <= busy_d;
      rd_idx_q   <= rd_idx_d;
      rd_phase_q <= rd_phase_d;
      dout_q     <= dout_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
    end
  end

  assign bus_dout = dout_q;
  assign red      = red_q;
  assign green    = green_q;
  assign blue     = blue_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_cga_palette_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cga_palette_ctrl
//   Directed self-checking bench for cga_palette_ctrl. Inputs change on the
//   falling edge and outputs are sampled on the following falling edge, so
//   each pixel/bus task covers exactly one active edge.
// -----------------------------------------------------------------------------
module tb_cga_palette_ctrl;

  logic       clk;
  logic       reset_n;
  logic [1:0] bus_addr;
  logic [7:0] bus_din;
  logic       bus_wr;
  logic       bus_rd;
  logic [7:0] bus_dout;
  logic [3:0] video;
  logic       blank;
  logic [5:0] red;
  logic [6:0] green;
  logic [5:0] blue;
  logic       busy;

  int n_checks;
  int n_errors;

  cga_palette_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus_addr (bus_addr),
    .bus_din  (bus_din),
    .bus_wr   (bus_wr),
    .bus_rd   (bus_rd),
    .bus_dout (bus_dout),
    .video    (video),
    .blank    (blank),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .busy     (busy)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_addr = a;
    bus_din  = d;
    bus_wr   = 1'b1;
    @(negedge clk);
    bus_wr   = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    bus_addr = a;
    bus_rd   = 1'b1;
    @(negedge clk);
    bus_rd   = 1'b0;
    d        = bus_dout;
  endtask

  task automatic pixel(input logic [3:0] v, input logic b);
    @(negedge clk);
    video = v;
    blank = b;
    @(negedge clk);
  endtask

  task automatic check_rgb(input string tag, input logic [5:0] r,
                           input logic [6:0] g, input logic [5:0] b);
    check_eq({tag, "_r"}, 32'(red),   32'(r));
    check_eq({tag, "_g"}, 32'(green), 32'(g));
    check_eq({tag, "_b"}, 32'(blue),  32'(b));
  endtask

  logic [7:0] rd;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    bus_addr = 2'd0;
    bus_din  = 8'h00;
    bus_wr   = 1'b0;
    bus_rd   = 1'b0;
    video    = 4'h6;
    blank    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_rgb("rst", 6'h00, 7'h00, 6'h00);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_dout", 32'(bus_dout), 32'h00);
    reset_n = 1'b1;

    // Default palette lookups
    pixel(4'h6, 1'b0); check_rgb("brown",  6'h2A, 7'h2A, 6'h00);
    pixel(4'hF, 1'b1); check_rgb("blankF", 6'h00, 7'h00, 6'h00);
    pixel(4'hF, 1'b0); check_rgb("white",  6'h3F, 7'h7F, 6'h3F);
    pixel(4'h8, 1'b0); check_rgb("dgray",  6'h15, 7'h2A, 6'h15);
    pixel(4'h1, 1'b0); check_rgb("blue",   6'h00, 7'h00, 6'h2A);
    bus_read(2'd3, rd); check_eq("status0", 32'(rd), 32'h00);

    // Triplet parked during active video, committed on blank
    bus_write(2'd0, 8'h03);
    bus_write(2'd1, 8'h3F);
    bus_write(2'd1, 8'h00);
    bus_write(2'd1, 8'h00);
    check_eq("park_busy", 32'(busy), 32'h1);
    bus_read(2'd3, rd); check_eq("park_status", 32'(rd), 32'h01);
    pixel(4'h3, 1'b0); check_rgb("cyan_old", 6'h00, 7'h55, 6'h2A);
    pixel(4'h3, 1'b1);
    check_eq("commit_busy", 32'(busy), 32'h0);
    check_rgb("commit_blank", 6'h00, 7'h00, 6'h00);
    pixel(4'h3, 1'b0); check_rgb("e3_new", 6'h3F, 7'h00, 6'h00);
    bus_read(2'd0, rd); check_eq("widx_4", 32'(rd), 32'h04);

    // Forced commit: two triplets back to back without blanking
    bus_write(2'd0, 8'h0F);
    bus_write(2'd1, 8'hC1);
    bus_write(2'd1, 8'h02);
    bus_write(2'd1, 8'h03);
    bus_write(2'd1, 8'h04);
    bus_write(2'd1, 8'h05);
    bus_write(2'd1, 8'h06);
    check_eq("force_busy", 32'(busy), 32'h1);
    bus_read(2'd0, rd); check_eq("widx_wrap", 32'(rd), 32'h01);
    pixel(4'hF, 1'b0); check_rgb("eF_forced", 6'h01, 7'h04, 6'h03);
    pixel(4'h0, 1'b0); check_rgb("e0_pend",   6'h00, 7'h00, 6'h00);
    pixel(4'h0, 1'b1); check_eq("force_clear", 32'(busy), 32'h0);
    pixel(4'h0, 1'b0); check_rgb("e0_new",    6'h04, 7'h0A, 6'h06);

    // Index write discards a partial triplet
    bus_write(2'd0, 8'h05);
    bus_write(2'd1, 8'h11);
    bus_write(2'd1, 8'h22);
    bus_write(2'd0, 8'h05);
    check_eq("partial_busy", 32'(busy), 32'h0);
    bus_write(2'd1, 8'h0A);
    bus_write(2'd1, 8'h0B);
    bus_write(2'd1, 8'h0C);
    pixel(4'h5, 1'b0); check_rgb("e5_old", 6'h2A, 7'h00, 6'h2A);
    pixel(4'h5, 1'b1);
    pixel(4'h5, 1'b0); check_rgb("e5_new", 6'h0A, 7'h16, 6'h0C);

    // Triplet completing inside blanking commits on the following edge
    pixel(4'h0, 1'b1);
    bus_write(2'd0, 8'h09);
    bus_write(2'd1, 8'h3F);
    bus_write(2'd1, 8'h3F);
    bus_write(2'd1, 8'h00);
    check_eq("blank_load_busy", 32'(busy), 32'h1);
    @(negedge clk);
    check_eq("blank_commit_busy", 32'(busy), 32'h0);
    pixel(4'h9, 1'b0); check_rgb("e9_new", 6'h3F, 7'h7F, 6'h00);

    // Simultaneous write and read of the write index returns the old index
    @(negedge clk);
    bus_addr = 2'd0;
    bus_din  = 8'h07;
    bus_wr   = 1'b1;
    bus_rd   = 1'b1;
    @(negedge clk);
    bus_wr   = 1'b0;
    bus_rd   = 1'b0;
    check_eq("wr_rd_old", 32'(bus_dout), 32'h0A);
    bus_read(2'd0, rd); check_eq("wr_rd_new", 32'(rd), 32'h07);
    bus_write(2'd2, 8'h3C);
    bus_read(2'd2, rd); check_eq("ridx", 32'(rd), 32'h0C);

`ifdef CGA_PAL_READBACK_EN
    // Readback of a committed entry, stepping into the next entry
    bus_write(2'd0, 8'h02);
    bus_write(2'd1, 8'h01);
    bus_write(2'd1, 8'h02);
    bus_write(2'd1, 8'h03);
    pixel(4'h0, 1'b1);
    pixel(4'h0, 1'b0);
    bus_write(2'd2, 8'h02);
    bus_read(2'd1, rd); check_eq("rb_r", 32'(rd), 32'h01);
    bus_read(2'd1, rd); check_eq("rb_g", 32'(rd), 32'h02);
    bus_read(2'd1, rd); check_eq("rb_b", 32'(rd), 32'h03);
    bus_read(2'd1, rd); check_eq("rb_next_r", 32'(rd), 32'h3F);
    bus_read(2'd2, rd); check_eq("rb_ridx", 32'(rd), 32'h03);
`else
    // Without readback the data port reads zero and the read index holds
    bus_read(2'd1, rd); check_eq("rb_off", 32'(rd), 32'h00);
    bus_read(2'd1, rd); check_eq("rb_off2", 32'(rd), 32'h00);
    bus_read(2'd2, rd); check_eq("rb_off_ridx", 32'(rd), 32'h0C);
`endif

    // Reset mid-operation drops the parked triplet and restores defaults
    bus_write(2'd0, 8'h04);
    bus_write(2'd1, 8'h01);
    bus_write(2'd1, 8'h02);
    bus_write(2'd1, 8'h03);
    check_eq("pre_rst_busy", 32'(busy), 32'h1);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check_eq("mid_rst_busy", 32'(busy), 32'h0);
    bus_read(2'd0, rd); check_eq("mid_rst_widx", 32'(rd), 32'h00);
    pixel(4'h4, 1'b1);
    pixel(4'h4, 1'b0); check_rgb("e4_dflt", 6'h2A, 7'h00, 6'h00);
    pixel(4'h3, 1'b0); check_rgb("e3_dflt", 6'h00, 7'h55, 6'h2A);
    pixel(4'hF, 1'b0); check_rgb("eF_dflt", 6'h3F, 7'h7F, 6'h3F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
